imem_arbiter: RTL and testbench

- Two-initiator responder for the single-port 64KB instruction memory, using the PicoRV32 native valid/ready protocol on both requester ports.
- Arbitrates between the CPU port (read/write) and the crypto accelerator's firmware-read port (read-only).
- Drives a synchronous-read RAM with proper wait states, replacing the instant-ready address mux.
- Flags out-of-window accesses.

---
 rtl/imem_arbiter.sv | 110 +++++++++++
 tb/tb_imem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-initiator arbiter for the single-port instruction RAM: CPU (read/write) and
// crypto firmware-read (DMA) ports, valid/ready protocol, synchronous-read RAM.
module imem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h00010000,
    parameter int          ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    input  logic              dma_valid,
    input  logic [31:0]       dma_addr,
    output logic              dma_ready,
    output logic [31:0]       dma_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              addr_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DMA = 1'b1;
    // 33-bit window bounds so an access near 32'hFFFFFFFC cannot wrap into range
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_W);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_grant;
    logic        r_last;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        w_take;
    logic        w_win;
    logic [32:0] w_addr33;
    logic        w_inwin;
    logic        w_rd_ok;

    always_comb begin
        w_take = cpu_valid | dma_valid;
        if (cpu_valid && dma_valid) begin
            w_win = ~r_last;
        end else begin
            w_win = cpu_valid ? GNT_CPU : GNT_DMA;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_nxt = S_ACC;
            S_ACC:   w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= GNT_CPU;
            r_last  <= GNT_DMA;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_take) begin
                r_grant <= w_win;
                r_last  <= w_win;
            end
        end
    end

    // Request payload is only consumed while the FSM is past IDLE, so it needs no reset
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_take) begin
            r_addr  <= (w_win == GNT_DMA) ? dma_addr : cpu_addr;
            r_wdata <= cpu_wdata;
            r_wstrb <= (w_win == GNT_DMA) ? 4'b0000 : cpu_wstrb;
        end
    end

    always_comb begin
        w_addr33 = {1'b0, r_addr} & ~33'd3;
        w_inwin  = (w_addr33 >= WIN_LO) && (w_addr33 < WIN_HI);
        w_rd_ok  = w_inwin && (r_wstrb == 4'b0000);
    end

    // RAM and requester outputs depend only on registered state
    always_comb begin
        ram_en    = (r_state == S_ACC) && w_inwin;
        ram_we    = ram_en ? r_wstrb : 4'b0000;
        ram_addr  = ram_en ? ADDR_W'((w_addr33 - WIN_LO) >> 2) : '0;
        ram_wdata = ram_en ? r_wdata : 32'h0;
        cpu_ready = (r_state == S_RESP) && (r_grant == GNT_CPU);
        dma_ready = (r_state == S_RESP) && (r_grant == GNT_DMA);
        cpu_rdata = (cpu_ready && w_rd_ok) ? ram_rdata : 32'h0;
        dma_rdata = (dma_ready && w_rd_ok) ? ram_rdata : 32'h0;
        addr_err  = (r_state == S_RESP) && !w_inwin;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus random two-port traffic, checked
// against a transaction-level model (grant alternation, fixed N+1/N+2 timing, memory image).
module tb_imem_arbiter;

    localparam logic [31:0] BASE = 32'h00010000;
    localparam int          AW   = 14;
    localparam int          NW   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_valid, dma_valid;
    logic [31:0]   cpu_addr, cpu_wdata, dma_addr;
    logic [3:0]    cpu_wstrb;
    logic          cpu_ready, dma_ready, ram_en, addr_err;
    logic [31:0]   cpu_rdata, dma_rdata, ram_wdata;
    logic [31:0]   ram_rdata = 32'h0;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;

    imem_arbiter #(.BASE_ADDR(BASE), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_ready(dma_ready),
        .dma_rdata(dma_rdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM with byte enables
    logic [31:0] mem [NW];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [NW];
    int          cyc = 0;
    int          t0  = -100;
    bit          last_dma = 1'b1;
    bit          m_dma = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
    logic [3:0]  m_wstrb = 4'h0;
    bit          cpu_pend = 1'b0, dma_pend = 1'b0, rnd = 1'b0;
    int          n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint unsigned x;
        x = 64'(a & 32'hFFFF_FFFC);
        return (x >= 64'(BASE)) && (x < 64'(BASE) + 64'(4 * NW));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2) & (NW - 1);
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return BASE + (32'($urandom_range(0, NW - 1)) << 2) + 32'($urandom_range(0, 3));
    endfunction

    task automatic req_cpu(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_pend = 1'b1;
    endtask

    task automatic req_dma(input logic [31:0] a);
        dma_valid = 1'b1; dma_addr = a; dma_pend = 1'b1;
    endtask

    // One clock: arbitration decision for the current cycle, then check the next cycle
    task automatic step();
        int          k;
        bit          win;
        logic [31:0] exp_rd;
        if (cyc >= t0 + 3 && (cpu_pend || dma_pend)) begin
            m_dma    = dma_pend && (!cpu_pend || !last_dma);
            last_dma = m_dma;
            t0       = cyc;
            m_addr   = m_dma ? dma_addr : cpu_addr;
            m_wdata  = cpu_wdata;
            m_wstrb  = m_dma ? 4'h0 : cpu_wstrb;
        end
        @(negedge clk);
        cyc++;
        k   = cyc - t0;
        win = in_win(m_addr);
        exp_rd = (win && m_wstrb == 4'h0) ? ref_mem[widx(m_addr)] : 32'h0;
        check("ram_en", 32'(ram_en), 32'(k == 1 && win));
        check("ram_we", 32'(ram_we), (k == 1 && win) ? 32'(m_wstrb) : 32'h0);
        if (k == 1 && win) begin
            check("ram_addr", 32'(ram_addr), 32'(widx(m_addr)));
            if (m_wstrb != 4'h0) check("ram_wdata", ram_wdata, m_wdata);
        end
        check("cpu_ready", 32'(cpu_ready), 32'(k == 2 && !m_dma));
        check("dma_ready", 32'(dma_ready), 32'(k == 2 && m_dma));
        check("addr_err", 32'(addr_err), 32'(k == 2 && !win));
        check("cpu_rdata", cpu_rdata, (k == 2 && !m_dma) ? exp_rd : 32'h0);
        check("dma_rdata", dma_rdata, (k == 2 && m_dma) ? exp_rd : 32'h0);
        if (k == 2) begin
            if (win)
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) ref_mem[widx(m_addr)][8*b +: 8] = m_wdata[8*b +: 8];
            if (m_dma) begin dma_valid = 1'b0; dma_pend = 1'b0; end
            else       begin cpu_valid = 1'b0; cpu_pend = 1'b0; end
        end
        if (rnd) begin
            if (!cpu_pend && $urandom_range(0, 2) == 0)
                req_cpu(rand_addr(), $urandom, $urandom_range(0, 1) ? 4'h0 : 4'($urandom));
            if (!dma_pend && $urandom_range(0, 2) == 0)
                req_dma(rand_addr());
        end
    endtask

    task automatic run_idle();
        int n = 0;
        do begin step(); n++; end
        while ((cpu_pend || dma_pend || cyc < t0 + 3) && n < 60);
        if (n >= 60) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        cpu_valid = 1'b0; dma_valid = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0; dma_addr = 32'h0;
        for (int i = 0; i < NW; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'h0);
        check("rst_dma_ready", 32'(dma_ready), 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_dma_rdata", dma_rdata, 32'h0);
        check("rst_ram_en", 32'(ram_en), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);
        rst_n = 1'b1;

        // Conflict straight out of reset, then a second conflict
        req_cpu(32'h00010004, 32'h0, 4'h0); req_dma(32'h0001FFFC); run_idle();
        req_cpu(32'h00010010, 32'h0, 4'h0); req_dma(32'h00010014); run_idle();

        // Lone CPU read, byte-masked write and read-back
        req_cpu(32'h00010000, 32'h0, 4'h0); run_idle();
        req_cpu(32'h00010008, 32'h11223344, 4'b0011); run_idle();
        req_cpu(32'h00010008, 32'h0, 4'h0); run_idle();
        req_cpu(32'h0001000C, 32'hAABBCCDD, 4'b0101); run_idle();
        req_dma(32'h0001000C); run_idle();

        // Out-of-window accesses
        req_cpu(32'h00020000, 32'h0, 4'h0); run_idle();
        req_cpu(32'h0000FFFC, 32'h0, 4'h0); run_idle();
        req_cpu(32'h00020000, 32'hFFFFFFFF, 4'hF); run_idle();
        req_dma(32'hFFFFFFFC); run_idle();

        // DMA drops valid while in ACC
        req_dma(32'h00010010);
        step();
        dma_valid = 1'b0; dma_pend = 1'b0;
        run_idle();
        repeat (3) step();

        // Reset while a CPU write is in ACC
        req_cpu(32'h00010020, 32'hA5A5A5A5, 4'hF);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_ram_we", 32'(ram_we), 32'h0);
        check("rst_mid_ram_en", 32'(ram_en), 32'h0);
        cpu_valid = 1'b0; cpu_pend = 1'b0;
        t0 = -100; last_dma = 1'b1;
        @(negedge clk); cyc++;
        check("rst_mid_cpu_ready", 32'(cpu_ready), 32'h0);
        rst_n = 1'b1;
        repeat (2) step();
        req_cpu(32'h00010024, 32'h0, 4'h0); req_dma(32'h00010028); run_idle();
        req_cpu(32'h00010020, 32'h0, 4'h0); run_idle();

        // Random two-port traffic
        rnd = 1'b1;
        repeat (1500) step();
        rnd = 1'b0;
        run_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
